// File: rtl/sma_controller.sv
// Sequencing controller for a simple-moving-average datapath: keeps a sliding window of
// samples, feeds it to an external adder tree and publishes the sum and average.
module sma_controller #(
  parameter int DATA_WIDTH  = 8,
  parameter int BUFFER_SIZE = 4,
  parameter int SUM_WIDTH   = $clog2(BUFFER_SIZE) + DATA_WIDTH,
  parameter int ROUND       = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              in_valid,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic                              in_ready,
  output logic [DATA_WIDTH*BUFFER_SIZE-1:0] buf_vector,
  input  logic [SUM_WIDTH-1:0]              sum_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [SUM_WIDTH-1:0]              out_sum,
  output logic [DATA_WIDTH-1:0]             out_avg,
  output logic [$clog2(BUFFER_SIZE):0]      fill_count,
  output logic                              primed
);

  localparam int SHIFT   = $clog2(BUFFER_SIZE);
  localparam int CW      = SHIFT + 1;
  localparam int RND_INT = (ROUND != 0) ? BUFFER_SIZE / 2 : 0;
  localparam logic [SUM_WIDTH:0] RND_ADD = RND_INT[SUM_WIDTH:0];
  localparam logic [CW-1:0] FULL = CW'(BUFFER_SIZE);

  typedef enum logic [1:0] {IDLE, SUM, OUT} state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] slot_reg   [BUFFER_SIZE];
  logic [DATA_WIDTH-1:0] slot_shift [BUFFER_SIZE];
  logic [CW-1:0]         fill_reg;
  logic [SUM_WIDTH-1:0]  out_sum_reg;
  logic [DATA_WIDTH-1:0] out_avg_reg;
  logic [SUM_WIDTH:0]    avg_full;
  logic [DATA_WIDTH-1:0] avg_trunc;
  logic                  accept;

  // Slot 0 takes the new sample; every other slot inherits its younger neighbour.
  genvar gi;
  generate
    for (gi = 0; gi < BUFFER_SIZE; gi++) begin : g_slot
      if (gi == 0) begin : g_head
        assign slot_shift[gi] = in_data;
      end else begin : g_tail
        assign slot_shift[gi] = slot_reg[gi-1];
      end
      assign buf_vector[DATA_WIDTH*(gi+1)-1 -: DATA_WIDTH] = slot_reg[gi];
    end
  endgenerate

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == OUT);
  assign accept     = in_valid && in_ready;
  assign primed     = (fill_reg == FULL);
  assign fill_count = fill_reg;
  assign out_sum    = out_sum_reg;
  assign out_avg    = out_avg_reg;

  // One extra bit keeps the rounding addend from wrapping at full scale.
  assign avg_full  = {1'b0, sum_in} + RND_ADD;
  assign avg_trunc = DATA_WIDTH'(avg_full >> SHIFT);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SUM;
      SUM:     state_next = primed ? OUT : IDLE;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_reg   <= IDLE;
      slot_reg    <= '{default: '0};
      fill_reg    <= '0;
      out_sum_reg <= '0;
      out_avg_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        slot_reg <= slot_shift;
        if (!primed) fill_reg <= fill_reg + CW'(1);
      end
      if (state_reg == SUM) begin
        out_sum_reg <= sum_in;
        out_avg_reg <= avg_trunc;
      end
    end
  end

endmodule
